alu_result_stage: RTL

//  Pipeline stage directly downstream of the ALU. Captures RESULT, Flag_Out and writeback tag into a 2-entry skid buffer.

---
 rtl/alu_result_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer feeding register-file writeback, plus the
// architectural N/Z/C/V flag register updated under mask when an entry is accepted.
module alu_result_stage #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int FLAG_W = 4
) (
   input  logic [4:0]        LOGISIM_CLOCK_TREE_0,
   input  logic              Reset,
   input  logic              Flush,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [DATA_W-1:0] In_Result,
   input  logic [FLAG_W-1:0] In_Flags,
   input  logic [FLAG_W-1:0] In_Flag_Mask,
   input  logic [RD_W-1:0]   In_Rd,
   input  logic              In_Wr_En,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [DATA_W-1:0] Out_Result,
   output logic [RD_W-1:0]   Out_Rd,
   output logic              Out_Wr_En,
   output logic [FLAG_W-1:0] Flags
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   logic              clk_s;
   logic              unused_clk_bits_s;
   state_t            state_r, state_next_s;
   logic              wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
   logic              push_s, pop_s;
   logic [DATA_W-1:0] mem_result_r [2];
   logic [RD_W-1:0]   mem_rd_r     [2];
   logic              mem_wr_en_r  [2];
   logic              head_valid_s, head_wr_en_s;
   logic [DATA_W-1:0] head_result_s;
   logic [RD_W-1:0]   head_rd_s;
   logic              in_ready_r, out_valid_r, out_wr_en_r;
   logic [DATA_W-1:0] out_result_r;
   logic [RD_W-1:0]   out_rd_r;
   logic [FLAG_W-1:0] flags_r;

   assign clk_s             = LOGISIM_CLOCK_TREE_0[4];
   assign unused_clk_bits_s = ^LOGISIM_CLOCK_TREE_0[3:0];

   assign push_s = In_Valid & in_ready_r & ~Flush;
   assign pop_s  = out_valid_r & Out_Ready & ~Flush;

   // Next-state and pointer logic; flush empties the buffer and rewinds both pointers.
   always_comb begin
      state_next_s  = state_r;
      wr_ptr_next_s = wr_ptr_r ^ push_s;
      rd_ptr_next_s = rd_ptr_r ^ pop_s;
      if (Flush) begin
         state_next_s  = ST_EMPTY;
         wr_ptr_next_s = 1'b0;
         rd_ptr_next_s = 1'b0;
      end else begin
         case (state_r)
            ST_EMPTY: if (push_s) state_next_s = ST_ONE; else state_next_s = ST_EMPTY;
            ST_ONE: begin
               if (push_s && !pop_s)      state_next_s = ST_FULL;
               else if (pop_s && !push_s) state_next_s = ST_EMPTY;
               else                       state_next_s = ST_ONE;
            end
            ST_FULL:  if (pop_s) state_next_s = ST_ONE; else state_next_s = ST_FULL;
            default:  state_next_s = ST_EMPTY;
         endcase
      end
   end

   // Head of the buffer after this edge; the incoming entry becomes head when it lands in the read slot.
   always_comb begin
      head_valid_s  = (state_next_s != ST_EMPTY);
      head_result_s = {DATA_W{1'b0}};
      head_rd_s     = {RD_W{1'b0}};
      head_wr_en_s  = 1'b0;
      if (!head_valid_s) begin
         head_result_s = {DATA_W{1'b0}};
      end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
         head_result_s = In_Result;
         head_rd_s     = In_Rd;
         head_wr_en_s  = In_Wr_En;
      end else begin
         head_result_s = mem_result_r[rd_ptr_next_s];
         head_rd_s     = mem_rd_r[rd_ptr_next_s];
         head_wr_en_s  = mem_wr_en_r[rd_ptr_next_s];
      end
   end

   // Buffer storage; contents are only ever observed through valid slots so no reset is needed.
   always_ff @(posedge clk_s) begin
      if (push_s) begin
         mem_result_r[wr_ptr_r] <= In_Result;
         mem_rd_r[wr_ptr_r]     <= In_Rd;
         mem_wr_en_r[wr_ptr_r]  <= In_Wr_En;
      end
   end

   // Control state, registered outputs and the architectural flag register.
   always_ff @(posedge clk_s) begin
      if (Reset) begin
         state_r      <= ST_EMPTY;
         wr_ptr_r     <= 1'b0;
         rd_ptr_r     <= 1'b0;
         in_ready_r   <= 1'b0;
         out_valid_r  <= 1'b0;
         out_result_r <= {DATA_W{1'b0}};
         out_rd_r     <= {RD_W{1'b0}};
         out_wr_en_r  <= 1'b0;
         flags_r      <= {FLAG_W{1'b0}};
      end else begin
         state_r      <= state_next_s;
         wr_ptr_r     <= wr_ptr_next_s;
         rd_ptr_r     <= rd_ptr_next_s;
         in_ready_r   <= (state_next_s != ST_FULL);
         out_valid_r  <= head_valid_s;
         out_result_r <= head_result_s;
         out_rd_r     <= head_rd_s;
         out_wr_en_r  <= head_wr_en_s;
         if (push_s) begin
            flags_r <= (flags_r & ~In_Flag_Mask) | (In_Flags & In_Flag_Mask);
         end
      end
   end

   assign In_Ready   = in_ready_r;
   assign Out_Valid  = out_valid_r;
   assign Out_Result = out_result_r;
   assign Out_Rd     = out_rd_r;
   assign Out_Wr_En  = out_wr_en_r;
   assign Flags      = flags_r;

endmodule
